// File: rtl/stage2.sv
// Stage 2: captures the stage-1 result on the rising edge of its done flag and
// runs 1..4 key-dependent rotate/XOR rounds, one per clock, before publishing.
module stage2 #(
  parameter int WIDTH = 16,
  parameter int ROT   = 1
) (
  input  logic             clk1,
  input  logic             rst,
  input  logic [4:0]       key_bits,
  input  logic [WIDTH-1:0] stg1_out,
  input  logic             stg1_done,
  input  logic             clr,
  output logic [WIDTH-1:0] stg2_out,
  output logic             done,
  output logic             busy,
  output logic             overrun
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_ROUND = 1'b1;

  logic [0:0]       r_state;
  logic [WIDTH-1:0] r_data;
  logic [4:0]       r_key;
  logic [1:0]       r_cnt;
  logic             r_prev_done;
  logic [WIDTH-1:0] r_out;
  logic             r_done;
  logic             r_busy;
  logic             r_overrun;

  logic             w_event;
  logic [WIDTH-1:0] w_next;

  // One round: rotate left by ROT (wrapping) then XOR in the zero-extended key.
  function automatic logic [WIDTH-1:0] f_round(input logic [WIDTH-1:0] d,
                                               input logic [4:0]       k);
    logic [WIDTH-1:0] rot;
    rot = (d << ROT) | (d >> (WIDTH - ROT));
    return rot ^ {{(WIDTH-5){1'b0}}, k};
  endfunction

  assign w_event = stg1_done & ~r_prev_done;
  assign w_next  = f_round(r_data, r_key);

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_data      <= '0;
      r_key       <= '0;
      r_cnt       <= '0;
      r_prev_done <= 1'b0;
      r_out       <= '0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_prev_done <= stg1_done;
      if (clr) begin
        // Abort: a coincident capture is dropped and is not an overrun.
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
        r_done  <= 1'b0;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_event) begin
              r_data  <= stg1_out;
              r_key   <= key_bits;
              r_cnt   <= key_bits[1:0];
              r_done  <= 1'b0;
              r_busy  <= 1'b1;
              r_state <= S_ROUND;
            end
          end
          default: begin
            r_data <= w_next;
            if (w_event) r_overrun <= 1'b1;
            if (r_cnt != 2'd0) begin
              r_cnt <= r_cnt - 2'd1;
            end else begin
              r_out   <= w_next;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end
          end
        endcase
      end
    end
  end

  assign stg2_out = r_out;
  assign done     = r_done;
  assign busy     = r_busy;
  assign overrun  = r_overrun;

endmodule
